sdram_arbit: RTL and testbench
==============================

# sdram_arbit

SDRAM command arbiter sitting directly downstream of the initialisation, auto-refresh, burst-write and burst-read stages; it is the only block driving the SDRAM pins. It selects one stage's command/bank/address bus, grants bus ownership with one-cycle-registered enables, and drives or tristates the 16-bit data bus. Priority is auto-refresh, then write, then read; initialisation owns the bus until `init_end`.

## Interface
Parameters:
- `DATA_W`, 16, SDRAM data bus width
- `ADDR_W`, 13, SDRAM address width

Ports:
- `sys_clk` in 1: single clock, 100 MHz SDRAM controller clock
- `sys_rst` in 1: reset, asynchronous, active-high
- `init_cmd`/`init_ba`/`init_addr` in 4/2/ADDR_W: init stage bus; `init_end` in 1: init done, level
- `aref_req` in 1, `aref_end` in 1, `aref_cmd`/`aref_ba`/`aref_addr` in 4/2/ADDR_W: refresh stage
- `wr_req` in 1, `wr_end` in 1, `wr_cmd`/`wr_ba`/`wr_addr` in 4/2/ADDR_W, `wr_data` in DATA_W, `wr_sdram_en` in 1: write stage
- `rd_req` in 1, `rd_end` in 1, `rd_cmd`/`rd_ba`/`rd_addr` in 4/2/ADDR_W: read stage
- `aref_en`/`wr_en`/`rd_en` out 1: grants
- `sdram_cke` out 1; `sdram_cs_n`/`sdram_ras_n`/`sdram_cas_n`/`sdram_we_n` out 1 each (cmd bits 3..0)
- `sdram_ba` out 2; `sdram_addr` out ADDR_W; `sdram_dq` inout DATA_W; `rd_data` out DATA_W

## Operation
- States: IDLE, ARBIT, AREF, WRITE, READ. Reset -> IDLE.
- IDLE: bus = init bus; all requests ignored; `init_end`=1 -> ARBIT.
- ARBIT: bus = NOP (cmd 4'b0111, ba 2'b11, addr all-ones). Priority: `aref_req` -> AREF, else `wr_req` -> WRITE, else `rd_req` -> READ, else stay.
- AREF/WRITE/READ: bus = owning stage's cmd/ba/addr; corresponding `*_end`=1 -> ARBIT. Other requests ignored until back in ARBIT (no preemption).
- Grant `x_en` is a registered flag: set on the edge entering state X, cleared on the edge leaving it; exactly one grant high at a time; `x_en`=1 iff state==X.
- `sdram_dq` = `wr_data` when `wr_sdram_en`=1, else high-Z; `rd_data` = `sdram_dq` continuously.
- `sdram_cke` = 1 whenever not in reset.
- `init_end` falling after IDLE has no effect; only reset returns to IDLE.

## Timing
- Reset values: state IDLE, all `*_en`=0, `sdram_cke`=0, cmd bus = `init_*` (combinational mux), `sdram_dq` high-Z unless `wr_sdram_en`.
- Command outputs are combinational from state register and selected stage bus; zero added latency.
- Grant latency: request sampled high at ARBIT edge N -> state and `x_en` valid after edge N.
- Release: `x_end` high at edge M -> ARBIT and `x_en`=0 after M; at least one NOP cycle (ARBIT) between consecutive grants.
- Simultaneous `x_end` and other requests: end wins, requests evaluated on next ARBIT cycle.
- Reset asserted mid-burst: immediate return to reset values; stage bus not selected; no NOP flush.
- Requests are levels; stage holds `*_req` until grant observed.

## Configuration
- `SDRAM_ARBIT_RR_EN` defined: write/read fairness. A 1-bit `last_wr` register (reset 0) records last granted of WRITE/READ; when both `wr_req` and `rd_req` high in ARBIT with no `aref_req`, grant the one not granted last. Refresh still absolute priority.
- Undefined: write always beats read; `last_wr` not implemented.

## Test plan
- Reset, then `init_cmd`=4'b0010 with `init_end`=0 -> `sdram_cs_n..we_n`=0,0,1,0; all grants 0; `sdram_cke`=1 after reset release.
- `init_end`=1, then `wr_req`=1 -> one NOP cycle, `wr_en`=1 next cycle, bus = `wr_cmd`; `wr_sdram_en`=1 with `wr_data`=16'h0005 -> `sdram_dq`=16'h0005; `wr_end` -> `wr_en`=0, NOP.
- `aref_req`, `wr_req`, `rd_req` all high in ARBIT -> `aref_en` first; after `aref_end`, `wr_en`; after `wr_end`, `rd_en`.
- `wr_end` and `aref_req` high same cycle -> ARBIT one cycle, then `aref_en`=1.
- Reset pulsed while `rd_en`=1 -> `rd_en`=0 immediately, state IDLE, bus = `init_*`.
- With `SDRAM_ARBIT_RR_EN`: `wr_req`,`rd_req` held high -> grants alternate WRITE, READ, WRITE; without -> WRITE every time.

Source files
------------

// File: rtl/sdram_arbit_if.sv
// Stage-side and SDRAM-pin signal bundle for the SDRAM command arbiter.
// master = the upstream stages/pins side, slave = the arbiter itself.
interface sdram_arbit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic [3:0]        init_cmd;
  logic [1:0]        init_ba;
  logic [ADDR_W-1:0] init_addr;
  logic              init_end;

  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [1:0]        aref_ba;
  logic [ADDR_W-1:0] aref_addr;

  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_sdram_en;

  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_ba;
  logic [ADDR_W-1:0] rd_addr;

  logic              aref_en;
  logic              wr_en;
  logic              rd_en;

  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [1:0]        sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output init_cmd, init_ba, init_addr, init_end,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_data, wr_sdram_en,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, rd_data
  );

  modport slave (
    input  init_cmd, init_ba, init_addr, init_end,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_data, wr_sdram_en,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, rd_data
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: refresh > write > read, init owns the bus until init_end.
// Optional SDRAM_ARBIT_RR_EN alternates write/read when both request together.
module sdram_arbit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  sdram_arbit_if.slave      bus,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t            state_reg, state_next;
  logic              aref_en_reg, wr_en_reg, rd_en_reg;
  logic              cke_reg;
  logic              grant_wr;
  logic [3:0]        cmd_sel;
  logic [1:0]        ba_sel;
  logic [ADDR_W-1:0] addr_sel;

`ifdef SDRAM_ARBIT_RR_EN
  logic last_wr_reg;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_wr_reg <= 1'b0;
    end else if (state_reg == ARBIT && state_next == WRITE) begin
      last_wr_reg <= 1'b1;
    end else if (state_reg == ARBIT && state_next == READ) begin
      last_wr_reg <= 1'b0;
    end
  end

  // Contended write/read goes to whichever was not served last.
  assign grant_wr = !last_wr_reg;
`else
  assign grant_wr = 1'b1;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg   <= IDLE;
      aref_en_reg <= 1'b0;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      cke_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aref_en_reg <= (state_next == AREF);
      wr_en_reg   <= (state_next == WRITE);
      rd_en_reg   <= (state_next == READ);
      cke_reg     <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.init_end) state_next = ARBIT;
      end
      ARBIT: begin
        if (bus.aref_req) begin
          state_next = AREF;
        end else if (bus.wr_req && bus.rd_req) begin
          state_next = grant_wr ? WRITE : READ;
        end else if (bus.wr_req) begin
          state_next = WRITE;
        end else if (bus.rd_req) begin
          state_next = READ;
        end
      end
      AREF: begin
        if (bus.aref_end) state_next = ARBIT;
      end
      WRITE: begin
        if (bus.wr_end) state_next = ARBIT;
      end
      READ: begin
        if (bus.rd_end) state_next = ARBIT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_sel  = CMD_NOP;
    ba_sel   = 2'b11;
    addr_sel = {ADDR_W{1'b1}};
    case (state_reg)
      IDLE: begin
        cmd_sel  = bus.init_cmd;
        ba_sel   = bus.init_ba;
        addr_sel = bus.init_addr;
      end
      AREF: begin
        cmd_sel  = bus.aref_cmd;
        ba_sel   = bus.aref_ba;
        addr_sel = bus.aref_addr;
      end
      WRITE: begin
        cmd_sel  = bus.wr_cmd;
        ba_sel   = bus.wr_ba;
        addr_sel = bus.wr_addr;
      end
      READ: begin
        cmd_sel  = bus.rd_cmd;
        ba_sel   = bus.rd_ba;
        addr_sel = bus.rd_addr;
      end
      default: begin
        cmd_sel  = CMD_NOP;
        ba_sel   = 2'b11;
        addr_sel = {ADDR_W{1'b1}};
      end
    endcase
  end

  assign bus.aref_en     = aref_en_reg;
  assign bus.wr_en       = wr_en_reg;
  assign bus.rd_en       = rd_en_reg;
  assign bus.sdram_cke   = cke_reg;
  assign bus.sdram_cs_n  = cmd_sel[3];
  assign bus.sdram_ras_n = cmd_sel[2];
  assign bus.sdram_cas_n = cmd_sel[1];
  assign bus.sdram_we_n  = cmd_sel[0];
  assign bus.sdram_ba    = ba_sel;
  assign bus.sdram_addr  = addr_sel;

  assign sdram_dq    = bus.wr_sdram_en ? bus.wr_data : {DATA_W{1'bz}};
  assign bus.rd_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: expectations queued at stimulus time, popped
// and asserted against DUT outputs one clock later.
module tb_sdram_arbit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;

  localparam logic [3:0] INIT_C = 4'b0010;
  localparam logic [3:0] AREF_C = 4'b0001;
  localparam logic [3:0] WR_C   = 4'b0100;
  localparam logic [3:0] RD_C   = 4'b0101;
  localparam logic [3:0] NOP_C  = 4'b0111;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              tb_dq_en = 1'b0;
  logic [DATA_W-1:0] tb_dq_val = '0;
  wire  [DATA_W-1:0] sdram_dq;

  int errors = 0;
  int checks = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];
  bit          last_wr_m;
  bit          exp_wr;

  sdram_arbit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sdram_arbit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus),
    .sdram_dq (sdram_dq)
  );

  assign sdram_dq = tb_dq_en ? tb_dq_val : {DATA_W{1'bz}};

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  task automatic push_state(input string tag, input logic [2:0] grants, input logic [3:0] cmd);
    push({tag, ".grant"}, {29'd0, grants});
    push({tag, ".cmd"}, {28'd0, cmd});
  endtask

  task automatic observe_state();
    pop_check({29'd0, bus.aref_en, bus.wr_en, bus.rd_en});
    pop_check({28'd0, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n});
  endtask

  initial begin
    bus.init_cmd = INIT_C;  bus.init_ba = 2'b00; bus.init_addr = 13'h0400; bus.init_end = 1'b0;
    bus.aref_cmd = AREF_C;  bus.aref_ba = 2'b01; bus.aref_addr = 13'h0a0a;
    bus.wr_cmd   = WR_C;    bus.wr_ba   = 2'b10; bus.wr_addr   = 13'h0123;
    bus.rd_cmd   = RD_C;    bus.rd_ba   = 2'b01; bus.rd_addr   = 13'h0456;
    bus.aref_req = 1'b0; bus.aref_end = 1'b0;
    bus.wr_req = 1'b0; bus.wr_end = 1'b0; bus.wr_data = '0; bus.wr_sdram_en = 1'b0;
    bus.rd_req = 1'b0; bus.rd_end = 1'b0;

    // Reset held: no grants, cke low, init bus on the pins.
    push_state("rst", 3'b000, INIT_C);
    push("rst.cke", 32'd0);
    repeat (2) tick();
    observe_state();
    pop_check({31'd0, bus.sdram_cke});

    // Out of reset, init not done: requests ignored.
    sys_rst = 1'b0;
    bus.wr_req = 1'b1;
    push_state("idle", 3'b000, INIT_C);
    push("idle.cke", 32'd1);
    push("idle.addr", 32'h0400);
    tick();
    observe_state();
    pop_check({31'd0, bus.sdram_cke});
    pop_check({19'd0, bus.sdram_addr});

    // init_end -> one NOP cycle before the pending write is granted.
    bus.init_end = 1'b1;
    push_state("arbit", 3'b000, NOP_C);
    push("arbit.addr", 32'h1fff);
    push("arbit.ba", 32'd3);
    tick();
    observe_state();
    pop_check({19'd0, bus.sdram_addr});
    pop_check({30'd0, bus.sdram_ba});
    bus.init_end = 1'b0;

    push_state("write", 3'b010, WR_C);
    push("write.addr", 32'h0123);
    tick();
    observe_state();
    pop_check({19'd0, bus.sdram_addr});
    bus.wr_req = 1'b0;

    bus.wr_sdram_en = 1'b1;
    bus.wr_data = 16'h0005;
    push("wr_dq", 32'h0005);
    #1;
    pop_check({16'd0, bus.rd_data});

    bus.wr_end = 1'b1;
    push_state("wr_release", 3'b000, NOP_C);
    tick();
    observe_state();
    bus.wr_end = 1'b0;
    bus.wr_sdram_en = 1'b0;

    // External device drives dq; rd_data follows.
    tb_dq_en = 1'b1;
    tb_dq_val = 16'ha5c3;
    push("rd_data", 32'ha5c3);
    #1;
    pop_check({16'd0, bus.rd_data});
    tb_dq_en = 1'b0;

    bus.rd_req = 1'b1;
    push_state("read", 3'b001, RD_C);
    tick();
    observe_state();
    bus.rd_req = 1'b0;
    bus.rd_end = 1'b1;
    push_state("rd_release", 3'b000, NOP_C);
    tick();
    observe_state();
    bus.rd_end = 1'b0;

    // All three requests: refresh, then write, then read.
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    push_state("pri_aref", 3'b100, AREF_C);
    tick();
    observe_state();
    bus.aref_req = 1'b0;
    bus.aref_end = 1'b1;
    push_state("aref_release", 3'b000, NOP_C);
    tick();
    observe_state();
    bus.aref_end = 1'b0;
    push_state("pri_wr", 3'b010, WR_C);
    tick();
    observe_state();
    bus.wr_req = 1'b0;
    bus.wr_end = 1'b1;
    push_state("wr_release2", 3'b000, NOP_C);
    tick();
    observe_state();
    bus.wr_end = 1'b0;
    push_state("pri_rd", 3'b001, RD_C);
    tick();
    observe_state();
    bus.rd_req = 1'b0;

    // No preemption, then end wins over a simultaneous request.
    bus.aref_req = 1'b1;
    push_state("no_preempt", 3'b001, RD_C);
    tick();
    observe_state();
    bus.rd_end = 1'b1;
    push_state("end_wins", 3'b000, NOP_C);
    tick();
    observe_state();
    bus.rd_end = 1'b0;
    push_state("aref_after_end", 3'b100, AREF_C);
    tick();
    observe_state();
    bus.aref_req = 1'b0;
    bus.aref_end = 1'b1;
    push_state("aref_release2", 3'b000, NOP_C);
    tick();
    observe_state();
    bus.aref_end = 1'b0;

    // Reset mid-read returns to init bus immediately.
    bus.rd_req = 1'b1;
    push_state("read2", 3'b001, RD_C);
    tick();
    observe_state();
    bus.rd_req = 1'b0;
    sys_rst = 1'b1;
    push_state("rst_mid", 3'b000, INIT_C);
    push("rst_mid.cke", 32'd0);
    #1;
    observe_state();
    pop_check({31'd0, bus.sdram_cke});
    tick();
    sys_rst = 1'b0;
    push_state("post_rst_idle", 3'b000, INIT_C);
    tick();
    observe_state();

    bus.init_end = 1'b1;
    push_state("arbit2", 3'b000, NOP_C);
    tick();
    observe_state();

    // Held write+read contention.
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    last_wr_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef SDRAM_ARBIT_RR_EN
      exp_wr = !last_wr_m;
`else
      exp_wr = 1'b1;
`endif
      push_state($sformatf("fair%0d", i), exp_wr ? 3'b010 : 3'b001, exp_wr ? WR_C : RD_C);
      tick();
      observe_state();
      last_wr_m = exp_wr;
      if (exp_wr) bus.wr_end = 1'b1;
      else        bus.rd_end = 1'b1;
      push_state($sformatf("fair%0d_rel", i), 3'b000, NOP_C);
      tick();
      observe_state();
      bus.wr_end = 1'b0;
      bus.rd_end = 1'b0;
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
